// File: rtl/priority_encoder_rr_if.sv
// priority_encoder_rr_if: request/grant bundle between requesters and the arbiter.
interface priority_encoder_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic [W-1:0] grant_idx;
    logic         grant_valid;
    logic         idle;
    modport master (output req, mode, ack, input grant_idx, grant_valid, idle);
    modport slave (input req, mode, ack, output grant_idx, grant_valid, idle);
endinterface

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr: fixed-priority / round-robin arbiter holding its grant until acknowledged.
module priority_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input logic clk,
    input logic rst,
    priority_encoder_rr_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t       state;
    logic [W-1:0] last;
    logic [W-1:0] base;
    logic [W-1:0] win;
    int           idx;
    // Fixed priority is round-robin anchored at 0: search runs base-1 downward, wrapping.
    assign base = bus.mode ? last : '0;
    always_comb begin
        win = '0;
        idx = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(base) + N - k) % N;
            if (|(bus.req & (N'(1) << idx))) win = W'(idx);
        end
    end
    assign bus.grant_valid = (state == GRANT);
    assign bus.idle = ~|bus.req & ~bus.grant_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.grant_idx <= '0;
            last          <= '0;
        end else if (state == IDLE || bus.ack) begin
            if (|bus.req) begin
                state         <= GRANT;
                bus.grant_idx <= win;
                last          <= win;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr: directed vectors for the 8-input and 5-input arbiter.
module tb_priority_encoder_rr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    priority_encoder_rr_if #(.N(8)) b8 ();
    priority_encoder_rr_if #(.N(5)) b5 ();
    priority_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    priority_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    int rr_seq[7] = '{0, 7, 6, 3, 0, 7, 6};
    int rr5_seq[4] = '{4, 1, 4, 1};
    initial begin
        b8.req = '0; b8.mode = 1'b0; b8.ack = 1'b0;
        b5.req = '0; b5.mode = 1'b0; b5.ack = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("rst_gv", b8.grant_valid, 0);
        check("rst_gi", b8.grant_idx, 0);
        check("rst_idle", b8.idle, 1);
        #2 rst = 1'b0;
        b8.req = 8'h01;
        #1;
        check("idle_follows_req", b8.idle, 0);
        tick();
        check("first_gv", b8.grant_valid, 1);
        check("first_gi", b8.grant_idx, 0);
        b8.mode = 1'b0; b8.req = 8'b1100_1001; b8.ack = 1'b1;
        tick();
        check("fixed_gi", b8.grant_idx, 7);
        b8.req = 8'h08; b8.ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gi", b8.grant_idx, 7);
            check("hold_gv", b8.grant_valid, 1);
        end
        b8.ack = 1'b1;
        tick();
        check("ack_regrant", b8.grant_idx, 3);
        b8.mode = 1'b1; b8.req = 8'hC9;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rr_gi", b8.grant_idx, rr_seq[i]);
            check("rr_gv", b8.grant_valid, 1);
        end
        b8.req = '0;
        tick();
        check("release_gv", b8.grant_valid, 0);
        check("release_idle", b8.idle, 1);
        check("release_gi_held", b8.grant_idx, 6);
        b8.ack = 1'b0;
        tick();
        check("idle_ack_ignored", b8.grant_valid, 0);
        b8.req = 8'h08;
        tick();
        check("pre_rst_gi", b8.grant_idx, 3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gv", b8.grant_valid, 0);
        check("async_rst_gi", b8.grant_idx, 0);
        b8.req = 8'hFF;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_gi", b8.grant_idx, 7);
        check("post_rst_gv", b8.grant_valid, 1);
        b8.req = '0; b8.ack = 1'b1;
        tick();
        check("drain_gv", b8.grant_valid, 0);
        b5.mode = 1'b1; b5.req = 5'b10010; b5.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("n5_rr_gi", b5.grant_idx, rr5_seq[i]);
        end
        b5.mode = 1'b0; b5.req = 5'b00001;
        tick();
        check("n5_fixed_gi", b5.grant_idx, 0);
        check("n5_fixed_gv", b5.grant_valid, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Registered, parametrised N-input priority encoder and arbiter with a grant/acknowledge handshake. It selects one active request line in one of two modes: fixed priority, where the highest index wins, or round-robin, with rotating priority. It holds the encoded grant index until the consumer acknowledges it. It replaces the combinational 8-to-3 encoder wherever several requesters share one downstream resource and starvation must be avoidable.

## Interface
Parameters:
- `N`, default 8: number of request lines; legal range ≥ 2.
- `W`, default `$clog2(N)`: width of the encoded index; not to be overridden.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `req`, input, N: request lines; bit i high means requester i is requesting.
- `mode`, input, 1: 0 selects fixed priority; 1 selects round-robin.
- `ack`, input, 1: consumer acknowledges the current grant.
- `grant_idx`, output, W: encoded index of the granted line; registered.
- `grant_valid`, output, 1: `grant_idx` is valid and held; registered.
- `idle`, output, 1: combinational, `(req == 0) & ~grant_valid`.

## Operation
- FSM states:
  - IDLE: no grant outstanding; `grant_valid` = 0.
  - GRANT: grant outstanding; `grant_valid` = 1.
- Internal register `last[W-1:0]` holds the index of the most recent grant.
- Arbitration, evaluated combinationally on `req`, `mode` and `last`:
  - mode 0: winner is the highest set bit of `req`. Order is N-1, N-2, …, 0.
  - mode 1: search starts at `last-1` and goes downward, wrapping from 0 to N-1. `last` itself is the lowest priority. Order is `last-1`, …, 0, N-1, …, `last`.
  - With `last` = 0, both modes produce the identical order.
- Transitions, on the rising edge:
  - IDLE and `req != 0`: go to GRANT. Load `grant_idx` = winner and `last` = winner.
  - IDLE and `req == 0`: stay in IDLE. `grant_idx` holds its value.
  - GRANT and `ack` = 0: stay in GRANT. `grant_idx` is frozen, even if `req` changes or the granted bit drops.
  - GRANT, `ack` = 1 and `req != 0`: re-arbitrate on the same edge. Stay in GRANT with the new winner, using the updated `last`. Back-to-back grants are allowed.
  - GRANT, `ack` = 1 and `req == 0`: go to IDLE.
- `last` updates on every grant, in both modes. The mode affects only winner selection.
- `mode` is sampled only on arbitration edges. Changing it mid-grant has no effect on the held grant.
- `ack` while in IDLE is ignored.
- Mode 0 may re-grant the same line indefinitely; starvation is allowed by design. Mode 1 guarantees each continuously asserted line a grant within N grants.

## Timing
- Reset (async assert, effective immediately, no clock required):
  - state = IDLE, `grant_valid` = 0, `grant_idx` = 0, `last` = 0.
  - `idle` = 1 if `req` = 0.
- Reset mid-grant drops `grant_valid` immediately and discards the grant. After release, the first mode-1 order is N-1 downward.
- Latency from `req` rising (IDLE, sampled at edge k) to `grant_valid`/`grant_idx` valid: 1 cycle, after edge k.
- Ack handling:
  - `ack` sampled high at edge k: the next grant, or `grant_valid` = 0, is visible after edge k.
  - Maximum throughput: one grant per cycle, with `ack` held high.
- `idle` is combinational. It follows `req` in the same cycle while in IDLE.
- All registered outputs are glitch-free. No combinational path runs from `req` or `ack` to `grant_idx` or `grant_valid`.

## Test plan
1. Reset and idle:
   - Stimulus: assert `rst` mid-cycle with `req` = 0.
   - Response: `grant_valid` = 0 and `grant_idx` = 0 immediately; `idle` = 1. Then set `req` = 8'h01: `idle` = 0 in the same cycle, and `grant_idx` = 0 with `grant_valid` = 1 after the next edge.
2. Fixed priority with hold:
   - Stimulus: `mode` = 0, `req` = 8'b1100_1001.
   - Response: `grant_idx` = 7 one cycle later.
   - Then change `req` to 8'h08 with `ack` = 0 for 5 cycles: `grant_idx` stays 7.
   - Then `ack` = 1 for one cycle: `grant_idx` = 3 after that edge.
3. Round-robin rotation:
   - Stimulus: `mode` = 1, `req` = 8'hC9 constant, `ack` = 1 every cycle.
   - Response: grant sequence 7, 6, 3, 0, 7, 6, … with `grant_valid` continuously 1.
4. Release to IDLE:
   - Stimulus: in GRANT, drive `req` = 0 and `ack` = 1.
   - Response: `grant_valid` = 0 after the edge, `idle` = 1, and `grant_idx` holds its last value.
5. Reset mid-operation:
   - Stimulus: in mode 1 with `last` = 3, assert `rst` asynchronously, then release with `req` = 8'hFF.
   - Response: `grant_valid` drops without a clock. The first post-reset grant is 7, not 2.
6. Non-power-of-two width:
   - Stimulus: N = 5 (W = 3), `mode` = 1, `req` = 5'b10010, `ack` = 1 each cycle.
   - Response: grants 4, 1, 4, 1.
   - Also: `mode` = 0 with `req` = 5'b00001 gives `grant_idx` = 0.
